// File: rtl/input_vc_buffer_pkg.sv
// Shared NoC types and constants used by the router input stage.
package noc_pkg;
   localparam int FLIT_WIDTH = 34;
   localparam int N_VIRT_CHN = 3;

   typedef enum logic [1:0] {
      HEAD_FLIT      = 2'b00,
      BODY_FLIT      = 2'b01,
      TAIL_FLIT      = 2'b10,
      HEAD_TAIL_FLIT = 2'b11
   } flit_type_e;

   typedef struct packed {
      flit_type_e                ftype;
      logic [FLIT_WIDTH-3:0]     payload;
   } s_flit_t;

   // Next VC in round-robin order, wrapping at n-1 -> 0.
   function automatic int rr_next(int vc, int n);
      return (vc + 1 >= n) ? 0 : vc + 1;
   endfunction
endpackage

// File: rtl/input_vc_buffer_if.sv
// Link-side and router-side handshake bundle of the input VC buffer.
interface input_vc_buffer_if #(
   parameter int FLIT_WIDTH = noc_pkg::FLIT_WIDTH,
   parameter int N_VIRT_CHN = noc_pkg::N_VIRT_CHN,
   parameter int VC_W       = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1
);
   logic                  fin_valid_i;
   logic [VC_W-1:0]       fin_vc_i;
   logic [FLIT_WIDTH-1:0] fin_flit_i;
   logic [N_VIRT_CHN-1:0] fin_ready_o;
   logic                  fout_valid_o;
   logic [VC_W-1:0]       fout_vc_o;
   logic [FLIT_WIDTH-1:0] fout_flit_o;
   logic                  fout_ready_i;
   logic                  err_ovf_o;

   // Upstream link plus downstream router: drives the buffer.
   modport master (
      output fin_valid_i, fin_vc_i, fin_flit_i, fout_ready_i,
      input  fin_ready_o, fout_valid_o, fout_vc_o, fout_flit_o, err_ovf_o
   );

   // The buffer itself.
   modport slave (
      input  fin_valid_i, fin_vc_i, fin_flit_i, fout_ready_i,
      output fin_ready_o, fout_valid_o, fout_vc_o, fout_flit_o, err_ovf_o
   );
endinterface

// File: rtl/input_vc_buffer_fifo.sv
// vc_fifo: one per-VC synchronous FIFO with wrap-bit pointers; storage is not reset.
module vc_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]                 wr_ptr, rd_ptr, count;
   logic [DEPTH-1:0][WIDTH-1:0] mem;

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/input_vc_buffer.sv
// Per-VC input buffering with round-robin arbitration and grant lock towards input_router.
// Optional same-cycle bypass when idle: define INPUT_VC_BUF_BYPASS_EN.
module input_vc_buffer #(
   parameter int FLIT_WIDTH = noc_pkg::FLIT_WIDTH,
   parameter int N_VIRT_CHN = noc_pkg::N_VIRT_CHN,
   parameter int BUF_DEPTH  = 4
) (
   input  logic               clk,
   input  logic               arst,
   input_vc_buffer_if.slave   bus
);
   import noc_pkg::*;

   localparam int VC_W = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;

   logic [N_VIRT_CHN-1:0]                 vc_push, vc_pop, vc_full, vc_empty;
   logic [N_VIRT_CHN-1:0][FLIT_WIDTH-1:0] vc_dout;

   logic            legal, wr_ok, byp, any_ne, out_valid, hs;
   logic [VC_W-1:0] gnt_rr, out_vc, rr_ptr, lock_vc_q;
   logic            lock_q, err_q;

   assign legal = int'(bus.fin_vc_i) < N_VIRT_CHN;
   // Full is sampled from registered pointers, so a pop this cycle never frees a slot for the write.
   assign wr_ok = bus.fin_valid_i && legal && !vc_full[bus.fin_vc_i];

`ifdef INPUT_VC_BUF_BYPASS_EN
   assign byp = (&vc_empty) && !lock_q && bus.fin_valid_i && legal;
`else
   assign byp = 1'b0;
`endif

   for (genvar v = 0; v < N_VIRT_CHN; v++) begin : g_vc
      assign vc_push[v] = wr_ok && (int'(bus.fin_vc_i) == v) && !(byp && bus.fout_ready_i);
      assign vc_pop[v]  = hs && !byp && (int'(out_vc) == v);

      vc_fifo #(.WIDTH(FLIT_WIDTH), .DEPTH(BUF_DEPTH)) u_fifo (
         .clk   (clk),
         .arst  (arst),
         .push  (vc_push[v]),
         .pop   (vc_pop[v]),
         .din   (bus.fin_flit_i),
         .dout  (vc_dout[v]),
         .full  (vc_full[v]),
         .empty (vc_empty[v])
      );
   end

   // Search upward from rr_ptr; iterating high-to-low lets the nearest candidate win.
   always_comb begin
      gnt_rr = '0;
      any_ne = 1'b0;
      for (int i = N_VIRT_CHN - 1; i >= 0; i--) begin
         if (!vc_empty[(int'(rr_ptr) + i) % N_VIRT_CHN]) begin
            gnt_rr = VC_W'((int'(rr_ptr) + i) % N_VIRT_CHN);
            any_ne = 1'b1;
         end
      end
   end

   always_comb begin
      out_valid        = lock_q || any_ne || byp;
      out_vc           = byp ? bus.fin_vc_i : (lock_q ? lock_vc_q : gnt_rr);
      bus.fout_valid_o = out_valid;
      bus.fout_vc_o    = '0;
      bus.fout_flit_o  = '0;
      if (out_valid) begin
         bus.fout_vc_o   = out_vc;
         bus.fout_flit_o = byp ? bus.fin_flit_i : vc_dout[out_vc];
      end
   end

   assign hs              = out_valid && bus.fout_ready_i;
   assign bus.fin_ready_o = ~vc_full;
   assign bus.err_ovf_o   = err_q;

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         rr_ptr    <= '0;
         lock_q    <= 1'b0;
         lock_vc_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (hs) begin
            rr_ptr <= VC_W'(rr_next(int'(out_vc), N_VIRT_CHN));
            lock_q <= 1'b0;
         end else if (out_valid) begin
            lock_q    <= 1'b1;
            lock_vc_q <= out_vc;
         end
         if (bus.fin_valid_i && !wr_ok) err_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer: scoreboard queue checked by a negedge monitor.
module tb_input_vc_buffer;
   import noc_pkg::*;

   localparam int FW = 34;
   localparam int NV = 3;
   localparam int BD = 4;

   logic clk  = 1'b0;
   logic arst = 1'b0;
   always #5 clk = ~clk;

   input_vc_buffer_if #(.FLIT_WIDTH(FW), .N_VIRT_CHN(NV)) bus();

   input_vc_buffer #(.FLIT_WIDTH(FW), .N_VIRT_CHN(NV), .BUF_DEPTH(BD)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   typedef struct packed {
      logic [1:0]    vc;
      logic [FW-1:0] flit;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every handshake must match the head of the scoreboard; idle outputs must be zero.
   always @(negedge clk) begin
      if (arst) begin
         if (bus.fout_valid_o && bus.fout_ready_i) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_out: got vc %0d flit 0x%0h, expected no output at %0t",
                        bus.fout_vc_o, bus.fout_flit_o, $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("out_vc",   64'(bus.fout_vc_o),   64'(mon_e.vc));
               chk("out_flit", 64'(bus.fout_flit_o), 64'(mon_e.flit));
            end
         end else if (!bus.fout_valid_o) begin
            chk("idle_zero", 64'({bus.fout_vc_o, bus.fout_flit_o}), 64'(0));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] vc, input logic [FW-1:0] f, input bit accept);
      if (accept) exp_q.push_back({vc, f});
      bus.fin_valid_i = 1'b1;
      bus.fin_vc_i    = vc;
      bus.fin_flit_i  = f;
      tick();
      bus.fin_valid_i = 1'b0;
      bus.fin_vc_i    = '0;
      bus.fin_flit_i  = '0;
   endtask

   task automatic do_reset();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
      bus.fin_valid_i  = 1'b0;
      bus.fout_ready_i = 1'b0;
      arst = 1'b0;
      tick();
      tick();
      arst = 1'b1;
      chk("rst_valid", 64'(bus.fout_valid_o), 64'(0));
      chk("rst_err",   64'(bus.err_ovf_o),    64'(0));
      chk("rst_ready", 64'(bus.fin_ready_o),  64'(3'b111));
   endtask

   initial begin
      bus.fin_valid_i  = 1'b0;
      bus.fin_vc_i     = '0;
      bus.fin_flit_i   = '0;
      bus.fout_ready_i = 1'b0;
      do_reset();
      chk("rst_vc",   64'(bus.fout_vc_o),   64'(0));
      chk("rst_flit", 64'(bus.fout_flit_o), 64'(0));

      // Single head flit on VC1 with the router ready.
      bus.fout_ready_i = 1'b1;
      exp_q.push_back({2'd1, 34'h0_0000_1234});
      bus.fin_valid_i = 1'b1;
      bus.fin_vc_i    = 2'd1;
      bus.fin_flit_i  = 34'h0_0000_1234;
      #1;
`ifdef INPUT_VC_BUF_BYPASS_EN
      chk("t1_byp_valid", 64'(bus.fout_valid_o), 64'(1));
      chk("t1_byp_vc",    64'(bus.fout_vc_o),    64'(1));
`else
      chk("t1_no_comb_path", 64'(bus.fout_valid_o), 64'(0));
`endif
      tick();
      bus.fin_valid_i = 1'b0;
      bus.fin_vc_i    = '0;
      bus.fin_flit_i  = '0;
`ifndef INPUT_VC_BUF_BYPASS_EN
      chk("t1_valid", 64'(bus.fout_valid_o), 64'(1));
      chk("t1_vc",    64'(bus.fout_vc_o),    64'(1));
      chk("t1_flit",  64'(bus.fout_flit_o),  64'(34'h0_0000_1234));
`endif
      chk("t1_fin_ready", 64'(bus.fin_ready_o), 64'(3'b111));
      tick();
      chk("t1_drained", 64'(bus.fout_valid_o), 64'(0));

      // Fill VC0, overflow it, then drain in order.
      do_reset();
      for (int i = 1; i <= 4; i++) wr(2'd0, 34'h1_0000_A000 + 34'(i), 1'b1);
      chk("t2_ready_full", 64'(bus.fin_ready_o), 64'(3'b110));
      chk("t2_held_vc",    64'(bus.fout_vc_o),   64'(0));
      chk("t2_held_flit",  64'(bus.fout_flit_o), 64'(34'h1_0000_A001));
      wr(2'd0, 34'h1_0000_A005, 1'b0);
      chk("t2_err", 64'(bus.err_ovf_o), 64'(1));
      bus.fout_ready_i = 1'b1;
      repeat (6) tick();
      chk("t2_ready_after", 64'(bus.fin_ready_o), 64'(3'b111));
      chk("t2_err_sticky",  64'(bus.err_ovf_o),   64'(1));

      // Round-robin over three preloaded VCs.
      do_reset();
      wr(2'd0, 34'h0_0000_B000, 1'b0);
      wr(2'd0, 34'h2_0000_B001, 1'b0);
      wr(2'd1, 34'h0_0000_B100, 1'b0);
      wr(2'd1, 34'h2_0000_B101, 1'b0);
      wr(2'd2, 34'h0_0000_B200, 1'b0);
      wr(2'd2, 34'h2_0000_B201, 1'b0);
      exp_q.push_back({2'd0, 34'h0_0000_B000});
      exp_q.push_back({2'd1, 34'h0_0000_B100});
      exp_q.push_back({2'd2, 34'h0_0000_B200});
      exp_q.push_back({2'd0, 34'h2_0000_B001});
      exp_q.push_back({2'd1, 34'h2_0000_B101});
      exp_q.push_back({2'd2, 34'h2_0000_B201});
      bus.fout_ready_i = 1'b1;
      repeat (8) tick();

      // Grant lock: rr_ptr points at VC2, yet the presented VC0 flit must hold.
      do_reset();
      bus.fout_ready_i = 1'b1;
      wr(2'd1, 34'h3_0000_D001, 1'b1);
      tick();
      bus.fout_ready_i = 1'b0;
      wr(2'd0, 34'h0_0000_C000, 1'b1);
      wr(2'd2, 34'h0_0000_C200, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("t4_lock_vc",   64'(bus.fout_vc_o),   64'(0));
         chk("t4_lock_flit", 64'(bus.fout_flit_o), 64'(34'h0_0000_C000));
         if (i < 2) tick();
      end
      bus.fout_ready_i = 1'b1;
      repeat (4) tick();

      // Full VC rejects even with a concurrent pop; push+pop keeps count.
      do_reset();
      for (int i = 0; i < 4; i++) wr(2'd0, 34'h1_0000_E000 + 34'(i), 1'b1);
      bus.fout_ready_i = 1'b1;
      wr(2'd0, 34'h1_0000_E004, 1'b0);
      chk("t5_err_full_pop", 64'(bus.err_ovf_o), 64'(1));
      tick();
      wr(2'd0, 34'h1_0000_E005, 1'b1);
      bus.fout_ready_i = 1'b0;
      chk("t5_cnt2_ready", 64'(bus.fin_ready_o[0]), 64'(1));
      wr(2'd0, 34'h1_0000_E006, 1'b1);
      chk("t5_cnt3_ready", 64'(bus.fin_ready_o), 64'(3'b111));
      wr(2'd0, 34'h1_0000_E007, 1'b1);
      chk("t5_cnt4_full", 64'(bus.fin_ready_o), 64'(3'b110));
      bus.fout_ready_i = 1'b1;
      repeat (6) tick();

      // Asynchronous reset mid-stream discards buffered flits.
      do_reset();
      wr(2'd0, 34'h0_0000_F000, 1'b0);
      wr(2'd1, 34'h0_0000_F100, 1'b0);
      wr(2'd2, 34'h0_0000_F200, 1'b0);
      chk("t6_valid_pre", 64'(bus.fout_valid_o), 64'(1));
      #3;
      arst = 1'b0;
      #1;
      chk("t6_async_valid", 64'(bus.fout_valid_o), 64'(0));
      chk("t6_async_ready", 64'(bus.fin_ready_o),  64'(3'b111));
      tick();
      bus.fout_ready_i = 1'b1;
      arst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t6_empty_after", 64'(bus.fout_valid_o), 64'(0));
         tick();
      end
      wr(2'd1, 34'h3_0000_F1F1, 1'b1);
      repeat (3) tick();

      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
